// File: rtl/mem_io_responder.sv
// mem_io_responder
// Responder for the core's 8-bit data-memory bus. Addresses below RAM_DEPTH
// hit a synchronous RAM. Addresses from IO_BASE upward reach a small set of
// peripherals:
//   +0 STATUS  : [0] empty, [1] full, [2] expired, [3] overflow, [6:4] count
//   +1 TXDATA  : a write pushes data into the output FIFO
//   +2 SWITCH  : switch levels, registered once
//   +3 TIMER   : a write loads reload and count; a read returns the count
//   +4 TCTRL   : [0] enable, [1] auto-reload
// Ports:
//   clock, reset           - system clock, synchronous active-high reset
//   MemRead, wren          - read / write strobes from the core
//   address, data          - byte address and write data
//   q                      - read data, registered (1-cycle latency)
//   sw_in                  - board switch levels
//   out_data, out_valid    - FIFO head and non-empty flag
//   out_ready              - consumer accepts the FIFO head
//   tmr_irq                - timer expired flag (sticky)
// All reads see pre-edge state, so a read and a write to the same address in
// one cycle return the old value.
module mem_io_responder #(
  parameter int         RAM_DEPTH  = 240,
  parameter logic [7:0] IO_BASE    = 8'hF0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  input  logic [7:0] sw_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       tmr_irq
);

  localparam int         PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [8:0] RAM_TOP  = 9'(RAM_DEPTH);
  localparam logic [2:0] FDEPTH   = 3'(FIFO_DEPTH);
  localparam logic [7:0] A_STATUS = IO_BASE;
  localparam logic [7:0] A_TX     = IO_BASE + 8'd1;
  localparam logic [7:0] A_SWITCH = IO_BASE + 8'd2;
  localparam logic [7:0] A_TIMER  = IO_BASE + 8'd3;
  localparam logic [7:0] A_TCTRL  = IO_BASE + 8'd4;

  // Pointer advance with explicit wrap so any depth works.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [7:0]    ram_mem  [0:RAM_DEPTH-1];
  logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];

  logic [7:0]    q_q, q_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          exp_q, exp_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    reload_q, reload_d;
  logic          en_q, en_d;
  logic          ar_q, ar_d;
  logic [7:0]    sw_q;

  logic          ram_sel_s, ram_we_s;
  logic          status_wr_s, tmr_wr_s, tctrl_wr_s;
  logic          pop_s, push_req_s, push_ok_s, drop_s, full_s, empty_s, expire_s;
  logic [7:0]    rd_s;

  assign ram_sel_s   = ({1'b0, address} < RAM_TOP);
  assign ram_we_s    = wren && ram_sel_s && !reset;
  assign status_wr_s = wren && (address == A_STATUS);
  assign tmr_wr_s    = wren && (address == A_TIMER);
  assign tctrl_wr_s  = wren && (address == A_TCTRL);
  assign push_req_s  = wren && (address == A_TX);

  assign empty_s     = (cnt_q == 3'd0);
  assign full_s      = (cnt_q == FDEPTH);
  assign pop_s       = !empty_s && out_ready;
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok_s   = push_req_s && (!full_s || pop_s);
  assign drop_s      = push_req_s && full_s && !pop_s;

  assign out_valid   = !empty_s;
  assign out_data    = empty_s ? 8'h00 : fifo_mem[head_q];
  assign tmr_irq     = exp_q;
  assign q           = q_q;

  // Read-data mux over pre-edge state.
  always_comb begin
    rd_s = 8'h00;
    if (ram_sel_s) begin
      rd_s = ram_mem[address];
    end else begin
      case (address)
        A_STATUS: rd_s = {1'b0, cnt_q, ovf_q, exp_q, full_s, empty_s};
        A_SWITCH: rd_s = sw_q;
        A_TIMER:  rd_s = tcnt_q;
        A_TCTRL:  rd_s = {6'b000000, ar_q, en_q};
        default:  rd_s = 8'h00;
      endcase
    end
  end

  // FIFO pointer/count next state and sticky overflow.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (pop_s) begin
      head_d = ptr_next(head_q);
    end else begin
      head_d = head_q;
    end
    if (push_ok_s) begin
      tail_d = ptr_next(tail_q);
    end else begin
      tail_d = tail_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (status_wr_s && data[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Timer next state: a TIMER write beats the countdown; expiry beats a clear.
  always_comb begin
    tcnt_d   = tcnt_q;
    reload_d = reload_q;
    expire_s = 1'b0;
    exp_d    = exp_q;
    en_d     = en_q;
    ar_d     = ar_q;
    if (tmr_wr_s) begin
      tcnt_d   = data;
      reload_d = data;
    end else if (en_q) begin
      if (tcnt_q > 8'd1) begin
        tcnt_d = tcnt_q - 8'd1;
      end else if (tcnt_q == 8'd1) begin
        expire_s = 1'b1;
        tcnt_d   = ar_q ? reload_q : 8'h00;
      end else begin
        tcnt_d = tcnt_q;
      end
    end else begin
      tcnt_d = tcnt_q;
    end
    if (tctrl_wr_s) begin
      en_d = data[0];
      ar_d = data[1];
    end else begin
      en_d = en_q;
      ar_d = ar_q;
    end
    if (expire_s) begin
      exp_d = 1'b1;
    end else if (status_wr_s && data[2]) begin
      exp_d = 1'b0;
    end else begin
      exp_d = exp_q;
    end
  end

  // Read-data register holds when no read is strobed.
  always_comb begin
    q_d = q_q;
    if (MemRead) begin
      q_d = rd_s;
    end else begin
      q_d = q_q;
    end
  end

  // Control and peripheral state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q      <= 8'h00;
      head_q   <= {PW{1'b0}};
      tail_q   <= {PW{1'b0}};
      cnt_q    <= 3'd0;
      ovf_q    <= 1'b0;
      exp_q    <= 1'b0;
      tcnt_q   <= 8'h00;
      reload_q <= 8'h00;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      sw_q     <= 8'h00;
    end else begin
      q_q      <= q_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      exp_q    <= exp_d;
      tcnt_q   <= tcnt_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      ar_q     <= ar_d;
      sw_q     <= sw_in;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_mem[address] <= data;
    end
  end

  // FIFO storage; entries beyond count are don't-care.
  always_ff @(posedge clock) begin
    if (push_ok_s && !reset) begin
      fifo_mem[tail_q] <= data;
    end
  end

endmodule
